// File: rtl/udma_filter_bincu_if.sv
// Sample stream into the BINCU and 1-bit binarized stream out of it.
// Both directions use a valid/ready handshake; a transfer happens when
// valid & ready are high at a rising clock edge.
//   input_data / input_valid / input_ready    : arithmetic-unit result stream
//   output_data / output_valid / output_ready : binarized stream
// Modports: master = stream producer/consumer side (testbench or upstream),
//           slave  = BINCU side.
interface udma_filter_bincu_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] input_data;
  logic                  input_valid;
  logic                  input_ready;
  logic                  output_data;
  logic                  output_valid;
  logic                  output_ready;

  modport master (
    output input_data, input_valid, output_ready,
    input  input_ready, output_data, output_valid
  );

  modport slave (
    input  input_data, input_valid, output_ready,
    output input_ready, output_data, output_valid
  );
endinterface

// File: rtl/udma_filter_bincu.sv
// udma_filter_bincu: binarization/counting unit of the uDMA filter datapath.
// Each accepted sample is extended to full width according to the configured
// datasize and signedness. It is then compared strictly against the
// threshold, and the 1-bit result goes out after one register stage. Results
// of 1 are counted while counting is enabled; the count saturates at its
// maximum. A one-cycle event fires the first time the count reaches the
// programmed target after a start.
//
// Optional build macro UDMA_FILTER_BINCU_HYST_EN adds cfg_hyst_i. The result
// then becomes a hysteresis state: it sets above the threshold, clears below
// (threshold - hyst), and otherwise holds its previous value.
//
// Ports:
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   cfg_use_signed_i    signed extension/compare when 1
//   cfg_datasize_i      00 byte, 01 halfword, 1x word
//   cfg_threshold_i     compare threshold
//   cfg_counter_i       event target count (0 = never)
//   cfg_en_counter_i    enable counting and event
//   cfg_hyst_i          hysteresis width (only with UDMA_FILTER_BINCU_HYST_EN)
//   cmd_start_i         clears the count and re-arms the event
//   stream              slave side of the sample/result handshake interface
//   counter_val_o       live count
//   act_event_o         one-cycle pulse when the target is reached
module udma_filter_bincu #(
  parameter int TRANS_SIZE = 15,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_use_signed_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic [DATA_WIDTH-1:0] cfg_threshold_i,
  input  logic [TRANS_SIZE-1:0] cfg_counter_i,
  input  logic                  cfg_en_counter_i,
`ifdef UDMA_FILTER_BINCU_HYST_EN
  input  logic [DATA_WIDTH-1:0] cfg_hyst_i,
`endif
  input  logic                  cmd_start_i,
  udma_filter_bincu_if.slave    stream,
  output logic [TRANS_SIZE-1:0] counter_val_o,
  output logic                  act_event_o
);

  localparam logic [TRANS_SIZE-1:0] CNT_MAX = '1;

  logic                  out_valid_q, out_valid_d;
  logic                  out_data_q,  out_data_d;
  logic [TRANS_SIZE-1:0] cnt_q,       cnt_d;
  logic                  armed_q,     armed_d;
  logic                  event_q,     event_d;
  logic                  hyst_q,      hyst_d;

  logic                  accept;
  logic [DATA_WIDTH-1:0] sample_ext;
  logic                  above;
  logic                  result;
  logic                  hyst_base;
  logic                  inc;

  assign stream.input_ready = ~out_valid_q | stream.output_ready;
  assign accept             = stream.input_valid & stream.input_ready;

  // Bits above the configured datasize become copies of the sample's sign
  // bit (signed) or zeros (unsigned).
  always_comb begin
    sample_ext = stream.input_data;
    case (cfg_datasize_i)
      2'b00: for (int i = 8; i < DATA_WIDTH; i++)
               sample_ext[i] = cfg_use_signed_i & stream.input_data[7];
      2'b01: for (int i = 16; i < DATA_WIDTH; i++)
               sample_ext[i] = cfg_use_signed_i & stream.input_data[15];
      default: ;
    endcase
  end

  assign above = cfg_use_signed_i ? ($signed(sample_ext) > $signed(cfg_threshold_i))
                                  : (sample_ext > cfg_threshold_i);

  // A start in the same cycle as an accept clears the hysteresis state
  // before the new sample is evaluated.
  assign hyst_base = cmd_start_i ? 1'b0 : hyst_q;

`ifdef UDMA_FILTER_BINCU_HYST_EN
  // The lower bound is computed two bits wider than the data so that
  // threshold - hyst cannot overflow. It is then clamped at the minimum
  // of the active number type.
  logic signed [DATA_WIDTH+1:0] thr_x, hyst_x, smp_x, low_x, min_x, low_sat;
  logic                         below;

  always_comb begin
    thr_x   = {{2{cfg_use_signed_i & cfg_threshold_i[DATA_WIDTH-1]}}, cfg_threshold_i};
    smp_x   = {{2{cfg_use_signed_i & sample_ext[DATA_WIDTH-1]}}, sample_ext};
    hyst_x  = {2'b00, cfg_hyst_i};
    low_x   = thr_x - hyst_x;
    min_x   = cfg_use_signed_i ? {3'b111, {(DATA_WIDTH-1){1'b0}}} : '0;
    low_sat = (low_x < min_x) ? min_x : low_x;
    below   = smp_x < low_sat;
  end

  assign result = above ? 1'b1 : (below ? 1'b0 : hyst_base);
`else
  assign result = above;
`endif

  assign hyst_d = accept ? result : hyst_base;
  assign inc    = accept & result & cfg_en_counter_i;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = result;
    end else if (stream.output_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // The event is evaluated only when the count actually moves, so a
  // saturated count that equals the target cannot re-trigger it.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    event_d = 1'b0;
    if (cmd_start_i) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end
    if (inc && (cmd_start_i || cnt_q != CNT_MAX)) begin
      cnt_d = cmd_start_i ? TRANS_SIZE'(1) : cnt_q + TRANS_SIZE'(1);
      if (armed_d && cfg_counter_i != '0 && cnt_d == cfg_counter_i) begin
        event_d = 1'b1;
        armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 1'b0;
      cnt_q       <= '0;
      armed_q     <= 1'b1;
      event_q     <= 1'b0;
      hyst_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      event_q     <= event_d;
      hyst_q      <= hyst_d;
    end
  end

  assign stream.output_valid = out_valid_q;
  assign stream.output_data  = out_data_q;
  assign counter_val_o       = cnt_q;
  assign act_event_o         = event_q;

endmodule

// File: doc/udma_filter_bincu.md
Name: udma_filter_bincu

Overview:
- Binarization/counting unit (BINCU) of the uDMA filter datapath; sits directly downstream of the filter register interface and consumes its committed bincu configuration (threshold, counter target, counter enable, datasize).
- Receives the arithmetic-unit result stream and emits a 1-bit-per-sample "above threshold" stream.
- Counts above-threshold samples and raises a one-cycle event when the programmed count is reached.
- Provides the live count read back by the register interface.

Parameters:
TRANS_SIZE, 15, width of counter target and live count
DATA_WIDTH, 32, width of input sample and threshold

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
cfg_use_signed_i  in  1  1 = sign-extend samples and signed compare; 0 = zero-extend, unsigned compare
cfg_datasize_i  in  2  sample width: 00 byte, 01 halfword, 10/11 word
cfg_threshold_i  in  DATA_WIDTH  compare threshold, full width
cfg_counter_i  in  TRANS_SIZE  event target count
cfg_en_counter_i  in  1  enable counting/event
cmd_start_i  in  1  one-cycle pulse from reg_if (cfg_filter_start_o); clears count and re-arms event
input_data_i  in  DATA_WIDTH  sample, data in LSBs
input_valid_i  in  1  sample valid
input_ready_o  out  1  sample accepted when valid & ready
output_data_o  out  1  binarized result
output_valid_o  out  1  result valid
output_ready_i  in  1  downstream ready
counter_val_o  out  TRANS_SIZE  live count (feeds bincu_counter_i)
act_event_o  out  1  one-cycle pulse on target reached

Behaviour:
- Reset: output_data_o=0, output_valid_o=0, counter_val_o=0, act_event_o=0, armed=1, hyst state=0.
- Extension: bits above the datasize are replaced by the sign bit (signed) or zeros (unsigned) before comparison; the threshold is used unmodified.
- Result: 1 when extended sample > threshold (strict), using signed or unsigned compare per cfg_use_signed_i.
- Pipeline:
  - One register stage; latency 1 cycle from accept to output_valid_o.
  - input_ready_o = ~output_valid_o | output_ready_i (combinational, no bubble at full throughput).
  - On accept: output_valid_o<=1 and output_data_o<=result.
  - On output handshake without a new accept: output_valid_o<=0.
  - output_data_o holds stable while valid & ~ready.
- Counter:
  - Each accepted sample with result 1 increments the count, provided cfg_en_counter_i=1.
  - Saturates at 2^TRANS_SIZE-1; no wrap.
  - Counting proceeds at accept time, independent of downstream stall.
- Event:
  - While armed, act_event_o pulses for one cycle in the cycle after an increment makes count == cfg_counter_i. Then armed<=0.
  - Further increments continue, up to saturation, with no further event until the next cmd_start_i.
  - cfg_counter_i=0: never fires.
- cmd_start_i:
  - Sets count to 0 and armed to 1.
  - Flushes nothing in the pipeline (an in-flight output is still delivered).
  - If a sample is accepted in the same cycle, start takes priority for the clear, and that sample is counted into the new window (count<=inc). If inc=1 and cfg_counter_i=1, the event fires the next cycle.
- cfg_en_counter_i=0: count holds and no event, but binarized output still flows.
- Config inputs are sampled live each cycle; reg_if guarantees they only change at commit.
- Reset mid-operation: all state returns to reset values immediately; any pending output is dropped.

Optional Feature:
- Macro: UDMA_FILTER_BINCU_HYST_EN.
- Defined:
  - Adds port cfg_hyst_i, in, DATA_WIDTH, non-negative hysteresis.
  - Result becomes stateful:
    - state sets to 1 when sample > threshold;
    - state clears to 0 when sample < threshold - cfg_hyst_i, where the subtraction uses the compare signedness and saturates at the type minimum;
    - otherwise state holds.
  - output_data_o is the new state.
  - cmd_start_i clears state to 0.
- Undefined: port absent; stateless strict compare as above.

Test Plan:
- Basic unsigned word compare:
  - Setup: threshold=100, datasize=10, signed=0.
  - Stimulus: samples 99, 100, 101, 0xFFFFFFFF with output_ready_i=1.
  - Required: outputs 0, 0, 1, 1, each one cycle after accept; counter_val_o=2 with en_counter=1.
- Signed byte extension:
  - Setup: datasize=00, signed=1, threshold=0xFFFFFFF0 (-16).
  - Stimulus: input 0x000000F8 (-8), then 0x000000E0 (-32).
  - Required: outputs 1, 0.
  - Rerun with signed=0, threshold=0x10: 0xF8 -> 1, 0xE0 -> 1.
- Event:
  - Setup: cfg_counter_i=3, en=1, pulse cmd_start_i.
  - Stimulus: 5 above-threshold samples.
  - Required: act_event_o high exactly one cycle, the cycle after the 3rd accept; count reaches 5; new start -> count 0 and event re-armed.
- Backpressure:
  - Stimulus: output_ready_i=0 for 4 cycles with input_valid_i=1.
  - Required: input_ready_o=0 after first accept; output_data_o stable; no sample lost or duplicated after release.
- Start/accept collision and saturation:
  - Setup: TRANS_SIZE=4.
  - Stimulus: 20 above-threshold samples.
  - Required: count saturates at 15.
  - Then cmd_start_i coincides with an above-threshold accept: count=1 the next cycle.
- Hysteresis (UDMA_FILTER_BINCU_HYST_EN):
  - Setup: threshold=100, hyst=10.
  - Stimulus: 101, 95, 89, 95.
  - Required: outputs 1, 1, 0, 0.
